// File: rtl/tod_pkg.sv
// Shared limits and BCD helpers for the time-of-day counter and its digit counters.
package tod_pkg;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HR24_MAX = 8'h23;
    localparam logic [7:0] HR12_MAX = 8'h12;
    localparam logic [7:0] HR12_MIN = 8'h01;
    localparam logic [7:0] BCD_ZERO = 8'h00;

    // Both digits must be decimal; once they are, packed BCD orders like binary.
    function automatic logic bcd_in_range(input logic [7:0] v,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
    endfunction

    function automatic logic tod_load_valid(input logic [7:0] hh,
                                            input logic [7:0] mm,
                                            input logic [7:0] ss,
                                            input logic       mode_24h);
        logic hh_ok;
        hh_ok = mode_24h ? bcd_in_range(hh, BCD_ZERO, HR24_MAX)
                         : bcd_in_range(hh, HR12_MIN, HR12_MAX);
        return hh_ok && bcd_in_range(mm, BCD_ZERO, MIN_MAX)
                     && bcd_in_range(ss, BCD_ZERO, SEC_MAX);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter wrapping MAX -> MIN, with synchronous clear and parallel load.
module bcd_mod_counter
    import tod_pkg::*;
#(
    parameter logic [7:0] MIN = 8'h00,
    parameter logic [7:0] MAX = 8'h59,
    parameter logic [7:0] RST = MIN
) (
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic       i_inc,
    input  logic       i_ld,
    input  logic [7:0] i_d,
    output logic [7:0] o_q,
    output logic       o_carry
);

    logic [7:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_clr)
            r_q <= RST;
        else if (i_ld)
            r_q <= i_d;
        else if (i_inc)
            r_q <= (r_q == MAX) ? MIN : bcd_inc(r_q);
    end

    assign o_q     = r_q;
    assign o_carry = i_inc & (r_q == MAX);

endmodule

// File: rtl/time_of_day_counter.sv
// HH:MM:SS packed-BCD clock with 1 Hz prescaler, parallel load and second/minute/day ticks.
module time_of_day_counter
    import tod_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter bit MODE_24H = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic       i_run,
    input  logic       i_ld,
    input  logic [7:0] i_ld_hh,
    input  logic [7:0] i_ld_mm,
    input  logic [7:0] i_ld_ss,
    input  logic       i_ld_pm,
    output logic [7:0] o_hh,
    output logic [7:0] o_mm,
    output logic [7:0] o_ss,
    output logic       o_pm,
    output logic       o_sec_tick,
    output logic       o_min_tick,
    output logic       o_day_tick,
    output logic       o_load_err
);

    localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]      HR_MIN     = MODE_24H ? BCD_ZERO : HR12_MIN;
    localparam logic [7:0]      HR_MAX     = MODE_24H ? HR24_MAX : HR12_MAX;
    localparam logic [7:0]      HR_RST     = MODE_24H ? BCD_ZERO : HR12_MAX;

    logic [PW-1:0] r_presc;
    logic          r_pm;
    logic          r_sec_tick;
    logic          r_min_tick;
    logic          r_day_tick;
    logic          r_load_err;

    logic          w_ld_valid;
    logic          w_ld_ok;
    logic          w_adv;
    logic          w_ss_carry;
    logic          w_mm_carry;
    logic          w_hh_carry;
    logic          w_pm_flip;
    logic          w_day;
    logic [7:0]    w_hh;
    logic [7:0]    w_mm;
    logic [7:0]    w_ss;

    assign w_ld_valid = tod_load_valid(i_ld_hh, i_ld_mm, i_ld_ss, MODE_24H);
    assign w_ld_ok    = i_ld & w_ld_valid;
    // Any load strobe, accepted or rejected, suppresses the advance for that cycle.
    assign w_adv      = i_run & ~i_ld & (r_presc == PRESC_LAST);

    bcd_mod_counter #(.MIN(BCD_ZERO), .MAX(SEC_MAX), .RST(BCD_ZERO)) u_ss (
        .i_clk   (i_clk),
        .i_clr   (i_clr),
        .i_inc   (w_adv),
        .i_ld    (w_ld_ok),
        .i_d     (i_ld_ss),
        .o_q     (w_ss),
        .o_carry (w_ss_carry)
    );

    bcd_mod_counter #(.MIN(BCD_ZERO), .MAX(MIN_MAX), .RST(BCD_ZERO)) u_mm (
        .i_clk   (i_clk),
        .i_clr   (i_clr),
        .i_inc   (w_ss_carry),
        .i_ld    (w_ld_ok),
        .i_d     (i_ld_mm),
        .o_q     (w_mm),
        .o_carry (w_mm_carry)
    );

    bcd_mod_counter #(.MIN(HR_MIN), .MAX(HR_MAX), .RST(HR_RST)) u_hh (
        .i_clk   (i_clk),
        .i_clr   (i_clr),
        .i_inc   (w_mm_carry),
        .i_ld    (w_ld_ok),
        .i_d     (i_ld_hh),
        .o_q     (w_hh),
        .o_carry (w_hh_carry)
    );

    // In 12h mode the meridiem flips on 11->12; midnight is 11 PM rolling into 12 AM.
    assign w_pm_flip = ~MODE_24H & w_mm_carry & (w_hh == 8'h11);
    assign w_day     = MODE_24H ? w_hh_carry : (w_pm_flip & r_pm);

    always_ff @(posedge i_clk) begin
        if (i_clr)
            r_presc <= '0;
        else if (w_ld_ok)
            r_presc <= '0;
        else if (i_run & ~i_ld)
            r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_clr)
            r_pm <= 1'b0;
        else if (w_ld_ok)
            r_pm <= MODE_24H ? 1'b0 : i_ld_pm;
        else if (w_pm_flip)
            r_pm <= ~r_pm;
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_sec_tick <= 1'b0;
            r_min_tick <= 1'b0;
            r_day_tick <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_sec_tick <= w_adv;
            r_min_tick <= w_ss_carry;
            r_day_tick <= w_day;
            r_load_err <= i_ld & ~w_ld_valid;
        end
    end

    assign o_hh       = w_hh;
    assign o_mm       = w_mm;
    assign o_ss       = w_ss;
    assign o_pm       = r_pm;
    assign o_sec_tick = r_sec_tick;
    assign o_min_tick = r_min_tick;
    assign o_day_tick = r_day_tick;
    assign o_load_err = r_load_err;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Scoreboard bench: a 24h and a 12h instance share stimulus; a seconds-of-day model predicts both.
module tb_time_of_day_counter;

    localparam int TICK_DIV = 4;
    localparam int DAY_SECS = 86400;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic       pm;
        logic       sec;
        logic       mn;
        logic       day;
        logic       err;
    } obs_t;

    logic       clk = 1'b0;
    logic       clr = 1'b0, run = 1'b0, ld = 1'b0, ld_pm = 1'b0;
    logic [7:0] ld_hh = 8'h00, ld_mm = 8'h00, ld_ss = 8'h00;

    logic [7:0] a_hh, a_mm, a_ss, b_hh, b_mm, b_ss;
    logic       a_pm, a_sec, a_min, a_day, a_err;
    logic       b_pm, b_sec, b_min, b_day, b_err;

    obs_t q24[$];
    obs_t q12[$];
    int   tod[2];
    int   presc[2];
    int   vectors = 0;
    int   miscompares = 0;

    logic [7:0] hh_pick [8] = '{8'h00, 8'h01, 8'h11, 8'h12, 8'h23, 8'h09, 8'h10, 8'h19};
    logic [7:0] mm_pick [4] = '{8'h59, 8'h58, 8'h00, 8'h30};
    logic [7:0] ss_pick [4] = '{8'h59, 8'h58, 8'h57, 8'h00};

    always #5 clk = ~clk;

    time_of_day_counter #(.TICK_DIV(TICK_DIV), .MODE_24H(1'b1)) dut24 (
        .i_clk(clk), .i_clr(clr), .i_run(run), .i_ld(ld),
        .i_ld_hh(ld_hh), .i_ld_mm(ld_mm), .i_ld_ss(ld_ss), .i_ld_pm(ld_pm),
        .o_hh(a_hh), .o_mm(a_mm), .o_ss(a_ss), .o_pm(a_pm),
        .o_sec_tick(a_sec), .o_min_tick(a_min), .o_day_tick(a_day), .o_load_err(a_err)
    );

    time_of_day_counter #(.TICK_DIV(TICK_DIV), .MODE_24H(1'b0)) dut12 (
        .i_clk(clk), .i_clr(clr), .i_run(run), .i_ld(ld),
        .i_ld_hh(ld_hh), .i_ld_mm(ld_mm), .i_ld_ss(ld_ss), .i_ld_pm(ld_pm),
        .o_hh(b_hh), .o_mm(b_mm), .o_ss(b_ss), .o_pm(b_pm),
        .o_sec_tick(b_sec), .o_min_tick(b_min), .o_day_tick(b_day), .o_load_err(b_err)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int from_bcd(input logic [7:0] v);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9)
            return -1;
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic obs_t view(input int t, input bit m24, input bit s, input bit m,
                                  input bit d, input bit e);
        obs_t o;
        int   h24;
        h24   = t / 3600;
        o.mm  = to_bcd((t / 60) % 60);
        o.ss  = to_bcd(t % 60);
        if (m24) begin
            o.hh = to_bcd(h24);
            o.pm = 1'b0;
        end else begin
            o.hh = to_bcd((h24 % 12 == 0) ? 12 : h24 % 12);
            o.pm = (h24 >= 12);
        end
        o.sec = s;
        o.mn  = m;
        o.day = d;
        o.err = e;
        return o;
    endfunction

    // Predicts the outputs after the coming edge; index 0 is the 24h instance, 1 the 12h one.
    function automatic obs_t model_step(input int i);
        bit m24 = (i == 0);
        int h, m, s, tgt;
        bit ok;
        bit st = 0, mt = 0, dt = 0, et = 0;
        if (clr) begin
            tod[i]   = 0;
            presc[i] = 0;
        end else if (ld) begin
            h  = from_bcd(ld_hh);
            m  = from_bcd(ld_mm);
            s  = from_bcd(ld_ss);
            ok = (m >= 0) && (m <= 59) && (s >= 0) && (s <= 59);
            if (m24) begin
                ok  = ok && (h >= 0) && (h <= 23);
                tgt = h;
            end else begin
                ok  = ok && (h >= 1) && (h <= 12);
                tgt = (h % 12) + (ld_pm ? 12 : 0);
            end
            if (ok) begin
                tod[i]   = tgt * 3600 + m * 60 + s;
                presc[i] = 0;
            end else begin
                et = 1;
            end
        end else if (run) begin
            if (presc[i] == TICK_DIV - 1) begin
                presc[i] = 0;
                tod[i]   = (tod[i] + 1) % DAY_SECS;
                st = 1;
                mt = (tod[i] % 60 == 0);
                dt = (tod[i] == 0);
            end else begin
                presc[i] = presc[i] + 1;
            end
        end
        return view(tod[i], m24, st, mt, dt, et);
    endfunction

    task automatic step(input bit c, input bit r, input bit l, input logic [7:0] h,
                        input logic [7:0] m, input logic [7:0] s, input bit p);
        @(negedge clk);
        clr = c; run = r; ld = l; ld_hh = h; ld_mm = m; ld_ss = s; ld_pm = p;
        q24.push_back(model_step(0));
        q12.push_back(model_step(1));
    endtask

    task automatic run_for(input int n);
        for (int k = 0; k < n; k++) step(0, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    endtask

    task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                        input bit p);
        step(0, 1, 1, h, m, s, p);
    endtask

    task automatic check(input string name, input obs_t act, input obs_t e);
        vectors++;
        if (act !== e) begin
            miscompares++;
            $display("FAIL %s t=%0t: got %h:%h:%h pm=%b s/m/d/e=%b%b%b%b, expected %h:%h:%h pm=%b s/m/d/e=%b%b%b%b",
                     name, $time, act.hh, act.mm, act.ss, act.pm, act.sec, act.mn, act.day, act.err,
                     e.hh, e.mm, e.ss, e.pm, e.sec, e.mn, e.day, e.err);
        end
    endtask

    always @(posedge clk) begin
        obs_t e;
        #1;
        if (q24.size() > 0) begin
            e = q24.pop_front();
            check("tod24", {a_hh, a_mm, a_ss, a_pm, a_sec, a_min, a_day, a_err}, e);
        end
        if (q12.size() > 0) begin
            e = q12.pop_front();
            check("tod12", {b_hh, b_mm, b_ss, b_pm, b_sec, b_min, b_day, b_err}, e);
        end
    end

    initial begin
        logic [7:0] h, m, s;
        int n;

        step(1, 0, 0, 8'h00, 8'h00, 8'h00, 0);
        run_for(9);

        load(8'h23, 8'h59, 8'h58, 0);
        run_for(10);

        run_for(2);
        load(8'h24, 8'h00, 8'h00, 0);
        load(8'h10, 8'h5A, 8'h00, 0);
        load(8'h00, 8'h00, 8'h00, 0);
        run_for(6);

        n = 0;
        while (presc[0] != TICK_DIV - 1 && n < 2 * TICK_DIV) begin
            run_for(1);
            n++;
        end
        load(8'h05, 8'h06, 8'h07, 0);
        run_for(6);

        load(8'h11, 8'h59, 8'h59, 0);
        run_for(5);
        load(8'h11, 8'h59, 8'h59, 1);
        run_for(5);

        run_for(2);
        for (int k = 0; k < 10; k++) step(0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
        run_for(6);
        step(0, 0, 1, 8'h12, 8'h34, 8'h56, 1);
        run_for(3);

        run_for(2);
        step(1, 1, 0, 8'h00, 8'h00, 8'h00, 0);
        run_for(5);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                h = hh_pick[$urandom_range(0, 7)];
                m = mm_pick[$urandom_range(0, 3)];
                s = ss_pick[$urandom_range(0, 3)];
            end else begin
                h = 8'($urandom);
                m = 8'($urandom);
                s = 8'($urandom);
            end
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 19) == 0, h, m, s, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        run = 1'b0; ld = 1'b0; clr = 1'b0;
        for (int k = 0; k < 5 && (q24.size() > 0 || q12.size() > 0); k++) @(posedge clk);
        #2;
        if (q24.size() > 0 || q12.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d/%0d pending expectations, expected 0/0",
                     q24.size(), q12.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
